// File: rtl/path_controller_if.sv
// rtl/path_controller_if.sv - control, tracker, path_math and transmitter signals of path_controller
// Signal groups:
//   run control  : go, abort, target
//   trackers     : location/loc_valid, orientation/orient_valid
//   path_math    : math_enable, math_location, math_target, math_orientation, math_done, math_command
//   transmitter  : tx_start, tx_command, tx_done
//   status       : busy, arrived, failed, iter_count, state
// master drives the environment side, slave is the controller itself.
interface path_controller_if;
    logic        go;
    logic        abort;
    logic [11:0] target;
    logic [11:0] location;
    logic        loc_valid;
    logic [4:0]  orientation;
    logic        orient_valid;
    logic        math_done;
    logic [11:0] math_command;
    logic        tx_done;

    logic        math_enable;
    logic [11:0] math_location;
    logic [11:0] math_target;
    logic [4:0]  math_orientation;
    logic        tx_start;
    logic [11:0] tx_command;
    logic        busy;
    logic        arrived;
    logic        failed;
    logic [3:0]  iter_count;
    logic [2:0]  state;

    modport master (
        output go, abort, target, location, loc_valid, orientation, orient_valid,
               math_done, math_command, tx_done,
        input  math_enable, math_location, math_target, math_orientation, tx_start,
               tx_command, busy, arrived, failed, iter_count, state
    );

    modport slave (
        input  go, abort, target, location, loc_valid, orientation, orient_valid,
               math_done, math_command, tx_done,
        output math_enable, math_location, math_target, math_orientation, tx_start,
               tx_command, busy, arrived, failed, iter_count, state
    );
endinterface

// File: rtl/path_controller.sv
// rtl/path_controller.sv - closed-loop sequencer driving path_math and the IR transmitter
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   bus   - path_controller_if.slave: run control, tracker samples, path_math and
//           transmitter handshakes, status outputs
module path_controller #(
    parameter logic [7:0]       TOL_R         = 8'd4,
    parameter int unsigned      CNT_W         = 24,
    parameter logic [CNT_W-1:0] SETTLE_CYCLES = 24'd6500000,
    parameter logic [3:0]       MAX_ITER      = 4'd8,
    parameter logic [5:0]       MATH_TIMEOUT  = 6'd32
) (
    input  logic              clock,
    input  logic              reset,
    path_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRESH = 3'd1,
        S_CALC       = 3'd2,
        S_CALC_WAIT  = 3'd3,
        S_DECIDE     = 3'd4,
        S_ISSUE      = 3'd5,
        S_TX_WAIT    = 3'd6,
        S_SETTLE     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      target_q, target_d;
    logic [11:0]      loc_q, loc_d;
    logic [4:0]       ori_q, ori_d;
    logic [11:0]      cmd_q, cmd_d;
    logic             loc_fresh_q, loc_fresh_d;
    logic             ori_fresh_q, ori_fresh_d;
    logic             done_q;
    logic             arrived_q, arrived_d;
    logic             failed_q, failed_d;
    logic [3:0]       iter_q, iter_d;
    logic [5:0]       to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             clr_fresh;
    logic             done_rise;

    // Only a fresh rising edge counts: path_math holds done high until its next
    // enable, so a level left over from the previous pass must be ignored.
    assign done_rise = bus.math_done & ~done_q;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        loc_d     = loc_q;
        ori_d     = ori_q;
        cmd_d     = cmd_q;
        arrived_d = arrived_q;
        failed_d  = failed_q;
        iter_d    = iter_q;
        to_cnt_d  = to_cnt_q;
        settle_d  = settle_q;
        clr_fresh = 1'b0;

        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.go) begin
                        target_d  = bus.target;
                        arrived_d = 1'b0;
                        failed_d  = 1'b0;
                        iter_d    = 4'd0;
                        clr_fresh = 1'b1;
                        state_d   = S_WAIT_FRESH;
                    end
                end
                S_WAIT_FRESH: begin
                    if (loc_fresh_q && ori_fresh_q) begin
                        loc_d     = bus.location;
                        ori_d     = bus.orientation;
                        clr_fresh = 1'b1;
                        state_d   = S_CALC;
                    end
                end
                S_CALC: begin
                    to_cnt_d = 6'd0;
                    state_d  = S_CALC_WAIT;
                end
                S_CALC_WAIT: begin
                    if (done_rise) begin
                        cmd_d   = bus.math_command;
                        state_d = S_DECIDE;
                    end else if (to_cnt_q == MATH_TIMEOUT - 6'd1) begin
                        failed_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 6'd1;
                    end
                end
                S_DECIDE: begin
                    if (cmd_q[7:0] <= TOL_R) begin
                        arrived_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (iter_q == MAX_ITER) begin
                        failed_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    iter_d  = iter_q + 4'd1;
                    state_d = S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (bus.tx_done) begin
                        settle_d = SETTLE_CYCLES;
                        state_d  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        // Samples taken while the rover was moving are stale.
                        clr_fresh = 1'b1;
                        state_d   = S_WAIT_FRESH;
                    end else begin
                        settle_d = settle_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A valid pulse coinciding with a clear still marks its sample fresh.
        loc_fresh_d = bus.loc_valid    | (loc_fresh_q & ~clr_fresh);
        ori_fresh_d = bus.orient_valid | (ori_fresh_q & ~clr_fresh);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            loc_q       <= '0;
            ori_q       <= '0;
            cmd_q       <= '0;
            loc_fresh_q <= 1'b0;
            ori_fresh_q <= 1'b0;
            done_q      <= 1'b0;
            arrived_q   <= 1'b0;
            failed_q    <= 1'b0;
            iter_q      <= '0;
            to_cnt_q    <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            loc_q       <= loc_d;
            ori_q       <= ori_d;
            cmd_q       <= cmd_d;
            loc_fresh_q <= loc_fresh_d;
            ori_fresh_q <= ori_fresh_d;
            done_q      <= bus.math_done;
            arrived_q   <= arrived_d;
            failed_q    <= failed_d;
            iter_q      <= iter_d;
            to_cnt_q    <= to_cnt_d;
            settle_q    <= settle_d;
        end
    end

    // Strobes are decoded from the registered state so an abort arriving in
    // ISSUE cannot suppress the tx_start pulse already in flight.
    assign bus.math_enable      = (state_q == S_CALC);
    assign bus.tx_start         = (state_q == S_ISSUE);
    assign bus.math_location    = loc_q;
    assign bus.math_target      = target_q;
    assign bus.math_orientation = ori_q;
    assign bus.tx_command       = cmd_q;
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.arrived          = arrived_q;
    assign bus.failed           = failed_q;
    assign bus.iter_count       = iter_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_path_controller.sv
// tb/tb_path_controller.sv - self-checking bench for path_controller
module tb_path_controller;
    localparam logic [7:0] TOL  = 8'd4;
    localparam int         MAXI = 8;

    logic clk;
    logic rst_n;

    path_controller_if pif();

    path_controller #(.SETTLE_CYCLES(24'd16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // environment controls (written by the main sequence only)
    bit          sensor_en;
    bit          man_loc, man_ori;
    logic [11:0] man_location;
    logic [4:0]  man_orient;
    int          math_mode;   // 0 normal, 1 stale-high, 2 never completes
    int          math_lat;
    bit          tx_hold;
    logic [11:0] cmd_tab[$];
    int          m_base;

    // state owned by the models / monitor
    int unsigned sc;
    int          m_cnt, lat_left, m_idx, tcnt;
    int          n_en, n_tx;
    logic [11:0] tx_log[$];

    // main-sequence scratch
    logic [11:0] vq[$];
    int          k, en0, tx0, r_nb;
    bit          r_arr, r_fail;
    int          r_iter;

    typedef struct {
        logic [11:0] tgt;
        logic [11:0] c_first;
        logic [11:0] c_later;
        int          n_first;
        bit          e_arr;
        bit          e_fail;
        int          e_iter;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Outcome of a run from the rules alone: each answer either arrives, hits the
    // move limit, or costs one more move.
    function automatic void ref_run(input logic [11:0] cmds[$], output bit arr,
                                    output bit fail, output int iter);
        arr = 1'b0; fail = 1'b0; iter = 0;
        foreach (cmds[i]) begin
            if (cmds[i][7:0] <= TOL) begin arr = 1'b1; return; end
            if (iter == MAXI) begin fail = 1'b1; return; end
            iter++;
        end
        arr = 1'b1;
    endfunction

    // tracker model: periodic pulses 5 cycles apart, or manual pulses
    initial begin : sensor_model
        pif.loc_valid = 1'b0; pif.orient_valid = 1'b0;
        pif.location = '0; pif.orientation = '0;
        sc = 0;
        forever begin
            @(negedge clk);
            sc++;
            pif.loc_valid    = sensor_en ? (sc % 20 == 0) : man_loc;
            pif.orient_valid = sensor_en ? (sc % 20 == 5) : man_ori;
            if (pif.loc_valid)    pif.location    = sensor_en ? 12'($urandom) : man_location;
            if (pif.orient_valid) pif.orientation = sensor_en ? 5'($urandom_range(0, 23)) : man_orient;
        end
    end

    // path_math model: done drops on enable, rises math_lat cycles later with the next answer
    initial begin : math_model
        pif.math_done = 1'b0; pif.math_command = '0;
        m_cnt = 0; lat_left = 0;
        forever begin
            @(negedge clk);
            if (math_mode == 1) begin
                pif.math_done = 1'b1; lat_left = 0;
            end else if (math_mode == 2) begin
                pif.math_done = 1'b0; lat_left = 0;
            end else if (pif.math_enable) begin
                pif.math_done = 1'b0; lat_left = math_lat; m_cnt++;
            end else if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    m_idx = m_cnt - 1 - m_base;
                    pif.math_command = (m_idx < cmd_tab.size()) ? cmd_tab[m_idx] : 12'h001;
                    pif.math_done = 1'b1;
                end
            end
        end
    end

    // transmitter model: tx_done 10 cycles after tx_start
    initial begin : tx_model
        pif.tx_done = 1'b0; tcnt = 0;
        forever begin
            @(negedge clk);
            pif.tx_done = 1'b0;
            if (pif.tx_start && !tx_hold) tcnt = 10;
            else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) pif.tx_done = 1'b1;
            end
        end
    end

    initial begin : monitor
        n_en = 0; n_tx = 0;
        forever begin
            @(negedge clk);
            if (pif.math_enable) n_en++;
            if (pif.tx_start) begin
                n_tx++;
                tx_log.push_back(pif.tx_command);
            end
        end
    end

    task automatic pulse_go(input logic [11:0] t);
        @(posedge clk); #1;
        pif.target = t; pif.go = 1'b1;
        @(posedge clk); #1;
        pif.go = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int w = 0;
        do begin @(negedge clk); w++; end while (pif.state !== s && w < 2000);
        check({tag, "_reach"}, 32'(pif.state), 32'(s));
    endtask

    task automatic run_case(input string tag, input logic [11:0] tgt, input logic [11:0] cmds[$],
                            input bit e_arr, input bit e_fail, input int e_iter);
        int cyc = 0;
        int e0, t0;
        cmd_tab = cmds; m_base = m_cnt; e0 = n_en; t0 = n_tx;
        pulse_go(tgt);
        do begin @(negedge clk); cyc++; end while (pif.busy && cyc < 3000);
        check({tag, "_done"},    32'(pif.busy), 32'd0);
        check({tag, "_arrived"}, 32'(pif.arrived), 32'(e_arr));
        check({tag, "_failed"},  32'(pif.failed), 32'(e_fail));
        check({tag, "_iter"},    32'(pif.iter_count), 32'(e_iter));
        check({tag, "_ntx"},     32'(n_tx - t0), 32'(e_iter));
        check({tag, "_nen"},     32'(n_en - e0), 32'(e_iter + 1));
        check({tag, "_target"},  32'(pif.math_target), 32'(tgt));
        for (int i = 0; i < e_iter && i < n_tx - t0; i++)
            check($sformatf("%s_txcmd%0d", tag, i), 32'(tx_log[t0 + i]), 32'(cmds[i]));
    endtask

    initial begin : main
        vecs[0] = '{12'h340, 12'h503, 12'h503,  0, 1'b1, 1'b0, 0};
        vecs[1] = '{12'h155, 12'h220, 12'h202,  1, 1'b1, 1'b0, 1};
        vecs[2] = '{12'h0F0, 12'h040, 12'h040, 16, 1'b0, 1'b1, 8};
        vecs[3] = '{12'h222, 12'h104, 12'h104,  0, 1'b1, 1'b0, 0};
        vecs[4] = '{12'h333, 12'h005, 12'h004,  1, 1'b1, 1'b0, 1};
        vecs[5] = '{12'h444, 12'hA80, 12'h000,  8, 1'b1, 1'b0, 8};
        vecs[6] = '{12'h555, 12'hA80, 12'h000,  9, 1'b0, 1'b1, 8};

        pif.go = 1'b0; pif.abort = 1'b0; pif.target = '0;
        sensor_en = 1'b0; man_loc = 1'b0; man_ori = 1'b0;
        man_location = '0; man_orient = '0;
        math_mode = 0; math_lat = 2; tx_hold = 1'b0; m_base = 0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",   32'(pif.state), 32'd0);
        check("rst_busy",    32'(pif.busy), 32'd0);
        check("rst_arrived", 32'(pif.arrived), 32'd0);
        check("rst_failed",  32'(pif.failed), 32'd0);
        check("rst_iter",    32'(pif.iter_count), 32'd0);
        check("rst_enable",  32'(pif.math_enable), 32'd0);
        check("rst_txstart", 32'(pif.tx_start), 32'd0);
        check("rst_txcmd",   32'(pif.tx_command), 32'd0);
        rst_n = 1'b1;

        // minimum latency: both samples arrive the cycle after go
        man_location = 12'h5A7; man_orient = 5'd13;
        vq.delete(); vq.push_back(12'h003); cmd_tab = vq; m_base = m_cnt;
        @(posedge clk); #1;
        pif.target = 12'h2C8; pif.go = 1'b1;
        @(posedge clk); #1;
        pif.go = 1'b0; man_loc = 1'b1; man_ori = 1'b1;
        @(posedge clk); #1;
        man_loc = 1'b0; man_ori = 1'b0;
        @(negedge clk);
        check("lat_early_enable", 32'(pif.math_enable), 32'd0);
        @(negedge clk);
        check("lat_enable",    32'(pif.math_enable), 32'd1);
        check("lat_snap_loc",  32'(pif.math_location), 32'h5A7);
        check("lat_snap_ori",  32'(pif.math_orientation), 32'd13);
        check("lat_target",    32'(pif.math_target), 32'h2C8);
        k = 0;
        do begin @(negedge clk); k++; end while (pif.busy && k < 500);
        check("lat_arrived", 32'(pif.arrived), 32'd1);

        // table of whole runs
        sensor_en = 1'b1;
        for (int v = 0; v < 7; v++) begin
            vq.delete();
            for (int i = 0; i < 12; i++)
                vq.push_back(i < vecs[v].n_first ? vecs[v].c_first : vecs[v].c_later);
            run_case($sformatf("vec%0d", v), vecs[v].tgt, vq,
                     vecs[v].e_arr, vecs[v].e_fail, vecs[v].e_iter);
        end

        // randomized runs against the rule model
        for (int r = 0; r < 6; r++) begin
            vq.delete();
            r_nb = $urandom_range(0, 10);
            for (int i = 0; i < r_nb; i++)
                vq.push_back({4'($urandom_range(0, 15)), 8'($urandom_range(5, 255))});
            vq.push_back({4'($urandom_range(0, 15)), 8'($urandom_range(0, 4))});
            math_lat = $urandom_range(1, 6);
            ref_run(vq, r_arr, r_fail, r_iter);
            run_case($sformatf("rnd%0d", r), 12'($urandom), vq, r_arr, r_fail, r_iter);
        end
        math_lat = 2;

        // stale math_done must time out rather than complete
        math_mode = 1;
        repeat (2) @(posedge clk);
        en0 = n_en; tx0 = n_tx;
        pulse_go(12'h0AB);
        @(negedge clk);
        check("stale_go_clr_arrived", 32'(pif.arrived), 32'd0);
        check("stale_go_clr_failed",  32'(pif.failed), 32'd0);
        k = 0;
        do begin @(negedge clk); k++; end while (!pif.math_enable && k < 500);
        check("stale_enable", 32'(pif.math_enable), 32'd1);
        k = 0;
        do begin @(negedge clk); if (pif.state == 3'd3) k++; end while (pif.state == 3'd3 && k < 100);
        check("stale_wait_cycles", 32'(k), 32'd32);
        check("stale_failed",  32'(pif.failed), 32'd1);
        check("stale_state",   32'(pif.state), 32'd0);
        check("stale_arrived", 32'(pif.arrived), 32'd0);
        check("stale_ntx",     32'(n_tx - tx0), 32'd0);
        check("stale_nen",     32'(n_en - en0), 32'd1);
        math_mode = 0;

        // abort during SETTLE
        vq.delete();
        for (int i = 0; i < 10; i++) vq.push_back(12'h040);
        cmd_tab = vq; m_base = m_cnt;
        pulse_go(12'h1F0);
        @(negedge clk);
        check("abort_go_clr_failed", 32'(pif.failed), 32'd0);
        wait_state(3'd7, "abort_settle");
        pif.abort = 1'b1;
        @(negedge clk);
        check("abort_settle_state",  32'(pif.state), 32'd0);
        check("abort_settle_busy",   32'(pif.busy), 32'd0);
        check("abort_settle_failed", 32'(pif.failed), 32'd0);
        pif.abort = 1'b0;

        // abort during TX_WAIT
        tx_hold = 1'b1;
        cmd_tab = vq; m_base = m_cnt;
        pulse_go(12'h1F1);
        wait_state(3'd6, "abort_txwait");
        pif.abort = 1'b1;
        @(negedge clk);
        check("abort_tx_state", 32'(pif.state), 32'd0);
        check("abort_tx_busy",  32'(pif.busy), 32'd0);
        pif.abort = 1'b0;
        tx_hold = 1'b0;

        // asynchronous reset in the middle of CALC_WAIT
        math_mode = 2;
        pulse_go(12'h3AB);
        wait_state(3'd3, "areset");
        #2 rst_n = 1'b0;
        #1;
        check("areset_state",   32'(pif.state), 32'd0);
        check("areset_busy",    32'(pif.busy), 32'd0);
        check("areset_target",  32'(pif.math_target), 32'd0);
        check("areset_txcmd",   32'(pif.tx_command), 32'd0);
        check("areset_loc",     32'(pif.math_location), 32'd0);
        check("areset_ori",     32'(pif.math_orientation), 32'd0);
        check("areset_iter",    32'(pif.iter_count), 32'd0);
        check("areset_arrived", 32'(pif.arrived), 32'd0);
        check("areset_failed",  32'(pif.failed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        math_mode = 0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/path_controller.md
Name: path_controller

Overview:
- Sequences the path_math datapath in a closed loop to drive the rover to a target.
- Per iteration: waits for a fresh ultrasound location and orientation sample, then snapshots them and triggers path_math.
- Then either declares arrival, or hands the move command to the IR transmitter and waits for the rover to settle before re-measuring.
- Sits between the location/orientation trackers, path_math and the transmitter.

Parameters:
TOL_R, 8'd4, arrival tolerance; command distance at or below this means arrived
SETTLE_CYCLES, 24'd6500000, post-transmit wait for rover motion (100 ms at 65 MHz)
MAX_ITER, 4'd8, move commands allowed before declaring failure
MATH_TIMEOUT, 6'd32, cycles allowed for path_math done
CNT_W, 24, settle counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
go  in  1  one-cycle pulse: start run toward target
abort  in  1  level: cancel run, return to IDLE
target  in  12  r[7:0], theta[11:8]; sampled on go
location  in  12  r[7:0], theta[11:8] from ultrasound tracker
loc_valid  in  1  one-cycle pulse: location updated
orientation  in  5  units of 15 deg
orient_valid  in  1  one-cycle pulse: orientation updated
math_done  in  1  path_math done (level, holds until next enable)
math_command  in  12  path_math move_command; angle[11:8], distance[7:0]
tx_done  in  1  one-cycle pulse: transmitter finished sending
math_enable  out  1  one-cycle start pulse to path_math
math_location  out  12  latched location snapshot
math_target  out  12  latched target
math_orientation  out  5  latched orientation snapshot
tx_start  out  1  one-cycle pulse to transmitter
tx_command  out  12  latched move command
busy  out  1  high in every state except IDLE
arrived  out  1  sticky; set on success, cleared on go
failed  out  1  sticky; set on timeout or iteration limit, cleared on go
iter_count  out  4  moves issued this run
state  out  3  current FSM state, for debug/hex display

Behaviour:
- Reset (reset low, async) clears every register and output to 0, state IDLE.
- States: IDLE=0, WAIT_FRESH=1, CALC=2, CALC_WAIT=3, DECIDE=4, ISSUE=5, TX_WAIT=6, SETTLE=7.
- IDLE
  - On go: latch target into math_target, clear arrived/failed/iter_count, clear fresh flags; go to WAIT_FRESH.
  - go is ignored when not in IDLE.
- WAIT_FRESH
  - Sticky loc_fresh and ori_fresh flags set on loc_valid / orient_valid.
  - When both flags are set: latch location and orientation snapshots, clear both flags, go to CALC.
  - A valid pulse arriving in the same cycle that the flags clear sets its flag again (set wins).
- CALC: math_enable=1 for exactly this cycle; timeout counter cleared; go to CALC_WAIT.
- CALC_WAIT
  - Register math_done each cycle.
  - Accept only a 0-to-1 edge of math_done. A stale high level from the previous run must not be taken as completion.
  - On edge: latch math_command into tx_command, go to DECIDE.
  - If the counter reaches MATH_TIMEOUT: failed=1, go to IDLE.
- DECIDE
  - tx_command[7:0] <= TOL_R: arrived=1, go to IDLE.
  - Else if iter_count == MAX_ITER: failed=1, go to IDLE.
  - Else go to ISSUE.
- ISSUE: tx_start=1 for one cycle, iter_count+1, go to TX_WAIT.
- TX_WAIT: on tx_done, load the settle counter with SETTLE_CYCLES, go to SETTLE. No timeout here.
- SETTLE
  - Counter decrements each cycle.
  - At 0: clear fresh flags, go to WAIT_FRESH. Samples taken during motion are discarded.
- abort is high-priority in any non-IDLE state:
  - Next state is IDLE; arrived/failed unchanged.
  - If abort coincides with tx_start, the pulse is still emitted.
- Latency go to math_enable: 2 cycles minimum, when both valid pulses land in the cycle after go.
- math_* and tx_command outputs are held stable between updates.

Test Plan:
- go with target=0x3_40 (r=64, theta=3). loc_valid and orient_valid pulse 5 cycles apart. Model returns 0x5_03 -> one math_enable, then arrived=1, tx_start never asserted, iter_count=0.
- Model returns 0x2_20 on the first pass and 0x2_02 on the second; tx_done returned 10 cycles after tx_start; SETTLE_CYCLES=16 for sim -> exactly one tx_start with tx_command=0x2_20, then arrived, iter_count=1.
- Model always returns distance 0x40 -> 8 tx_start pulses, then failed=1, arrived=0, iter_count=8.
- math_done held high from a prior run and never re-rises -> failed=1 exactly 32 cycles after CALC; no spurious DECIDE.
- abort asserted during SETTLE and TX_WAIT -> state=0 the next cycle, busy=0. A subsequent go clears failed/arrived.
- reset pulsed low mid-CALC_WAIT (asynchronous, off clock edge) -> all outputs 0 immediately, state=IDLE.
